// File: rtl/mul_acc_iter_pkg.sv
// rtl/mul_acc_iter_pkg.sv - shared op/state encodings and defaults for the iterative MAC
package mul_acc_iter_pkg;

    localparam int DEF_WIDTH          = 32;
    localparam int DEF_BITS_PER_CYCLE = 8;

    typedef enum logic [1:0] {
        OP_MUL  = 2'b00,
        OP_MLA  = 2'b01,
        OP_MULL = 2'b10,
        OP_MLAL = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_MULT = 2'b01,
        S_ACC  = 2'b10,
        S_DONE = 2'b11
    } state_e;

    // Long ops (MULL/MLAL) return the full 2W-bit product.
    function automatic logic is_long(input op_e op);
        return op[1];
    endfunction

endpackage

// File: rtl/mul_acc_iter_if.sv
// rtl/mul_acc_iter_if.sv - request/result handshake bundle for mul_acc_iter
interface mul_acc_iter_if #(
    parameter int WIDTH = 32
);
    logic             in_Valid;
    logic             out_InReady;
    logic [1:0]       in_Op;
    logic             in_Signed;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic [WIDTH-1:0] in_AccLow;
    logic [WIDTH-1:0] in_AccHigh;
    logic             in_Flush;
    logic             out_Valid;
    logic             in_OutReady;
    logic [WIDTH-1:0] out_ResultLow;
    logic [WIDTH-1:0] out_ResultHigh;
    logic             out_Neg;
    logic             out_Zero;

    // Requester / result consumer side.
    modport master (
        output in_Valid, in_Op, in_Signed, in_a, in_b, in_AccLow, in_AccHigh,
        output in_Flush, in_OutReady,
        input  out_InReady, out_Valid, out_ResultLow, out_ResultHigh, out_Neg, out_Zero
    );

    // Multiply unit side.
    modport slave (
        input  in_Valid, in_Op, in_Signed, in_a, in_b, in_AccLow, in_AccHigh,
        input  in_Flush, in_OutReady,
        output out_InReady, out_Valid, out_ResultLow, out_ResultHigh, out_Neg, out_Zero
    );

endinterface

// File: rtl/mul_iter_step.sv
// rtl/mul_iter_step.sv - W x K partial-product generator extended to 2W bits
module mul_iter_step
    import mul_acc_iter_pkg::*;
#(
    parameter int WIDTH          = DEF_WIDTH,
    parameter int BITS_PER_CYCLE = DEF_BITS_PER_CYCLE
) (
    input  logic [WIDTH-1:0]          a_i,
    input  logic [BITS_PER_CYCLE-1:0] slice_i,
    input  logic                      signed_i,
    output logic [2*WIDTH-1:0]        pp_o
);

    logic [2*WIDTH-1:0] a_ext;
    logic [2*WIDTH-1:0] slice_ext;

    // Multiplicand is sign- or zero-extended; the multiplier slice is always
    // unsigned, its sign weight is handled once by the correction in ACC.
    assign a_ext     = {{WIDTH{signed_i & a_i[WIDTH-1]}}, a_i};
    assign slice_ext = {{(2*WIDTH-BITS_PER_CYCLE){1'b0}}, slice_i};
    assign pp_o      = a_ext * slice_ext;

endmodule

// File: rtl/mul_acc_iter.sv
// rtl/mul_acc_iter.sv - iterative MUL/MLA/MULL/MLAL unit with valid/ready handshake
module mul_acc_iter
    import mul_acc_iter_pkg::*;
#(
    parameter int WIDTH          = DEF_WIDTH,
    parameter int BITS_PER_CYCLE = DEF_BITS_PER_CYCLE
) (
    input logic          clock,
    input logic          reset,
    mul_acc_iter_if.slave bus
);

    localparam int W     = WIDTH;
    localparam int K     = BITS_PER_CYCLE;
    localparam int C     = W / K;
    localparam int CNT_W = (C > 1) ? $clog2(C) : 1;
    localparam int SH_W  = $clog2(2 * W) + 1;

    state_e            state_q, state_d;
    op_e               op_q, op_d;
    logic              sgn_q, sgn_d;
    logic [W-1:0]      a_q, a_d;
    logic [W-1:0]      b_q, b_d;
    logic              bmsb_q, bmsb_d;
    logic [2*W-1:0]    acc_q, acc_d;
    logic [2*W-1:0]    p_q, p_d;
    logic [SH_W-1:0]   shamt_q, shamt_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [2*W-1:0]    res_q, res_d;
    logic              neg_q, neg_d;
    logic              zero_q, zero_d;

    logic [2*W-1:0]    pp;
    logic [2*W-1:0]    corr;
    logic [2*W-1:0]    sum;
    logic              in_ready;
    logic              out_valid;

    mul_iter_step #(
        .WIDTH          (W),
        .BITS_PER_CYCLE (K)
    ) u_step (
        .a_i      (a_q),
        .slice_i  (b_q[K-1:0]),
        .signed_i (sgn_q),
        .pp_o     (pp)
    );

    // Final sum: a signed multiplier with its top bit set was treated as
    // unsigned during MULT, so remove a * 2^W; then add the accumulator.
    always_comb begin
        corr = '0;
        if (sgn_q && bmsb_q) begin
            corr = {a_q, {W{1'b0}}};
        end
        sum = p_q - corr + acc_q;
    end

    // Next-state, datapath next values and handshake outputs.
    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        sgn_d     = sgn_q;
        a_d       = a_q;
        b_d       = b_q;
        bmsb_d    = bmsb_q;
        acc_d     = acc_q;
        p_d       = p_q;
        shamt_d   = shamt_q;
        cnt_d     = cnt_q;
        res_d     = res_q;
        neg_d     = neg_q;
        zero_d    = zero_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;

        case (state_q)
            S_IDLE: begin
                in_ready = 1'b1;
            end
            S_MULT: begin
                p_d     = p_q + (pp << shamt_q);
                b_d     = b_q >> K;
                shamt_d = shamt_q + SH_W'(K);
                cnt_d   = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(C - 1)) begin
                    state_d = S_ACC;
                end
            end
            S_ACC: begin
                if (is_long(op_q)) begin
                    res_d  = sum;
                    neg_d  = sum[2*W-1];
                    zero_d = (sum == '0);
                end else begin
                    res_d  = {{W{1'b0}}, sum[W-1:0]};
                    neg_d  = sum[W-1];
                    zero_d = (sum[W-1:0] == '0);
                end
                state_d = S_DONE;
            end
            S_DONE: begin
                out_valid = 1'b1;
                in_ready  = bus.in_OutReady;
                if (bus.in_OutReady) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (in_ready && bus.in_Valid && !bus.in_Flush) begin
            op_d    = op_e'(bus.in_Op);
            sgn_d   = bus.in_Signed;
            a_d     = bus.in_a;
            b_d     = bus.in_b;
            bmsb_d  = bus.in_b[W-1];
            p_d     = '0;
            shamt_d = '0;
            cnt_d   = '0;
            case (op_e'(bus.in_Op))
                OP_MLAL: acc_d = {bus.in_AccHigh, bus.in_AccLow};
                OP_MLA:  acc_d = {{W{1'b0}}, bus.in_AccLow};
                default: acc_d = '0;
            endcase
            state_d = S_MULT;
        end

        // Abort wins over everything, including a result being formed in ACC.
        if (bus.in_Flush) begin
            state_d = S_IDLE;
            res_d   = res_q;
            neg_d   = neg_q;
            zero_d  = zero_q;
        end
    end

    // State and datapath registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            op_q    <= OP_MUL;
            sgn_q   <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            bmsb_q  <= 1'b0;
            acc_q   <= '0;
            p_q     <= '0;
            shamt_q <= '0;
            cnt_q   <= '0;
            res_q   <= '0;
            neg_q   <= 1'b0;
            zero_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            sgn_q   <= sgn_d;
            a_q     <= a_d;
            b_q     <= b_d;
            bmsb_q  <= bmsb_d;
            acc_q   <= acc_d;
            p_q     <= p_d;
            shamt_q <= shamt_d;
            cnt_q   <= cnt_d;
            res_q   <= res_d;
            neg_q   <= neg_d;
            zero_q  <= zero_d;
        end
    end

    assign bus.out_InReady    = in_ready;
    assign bus.out_Valid      = out_valid;
    assign bus.out_ResultLow  = res_q[W-1:0];
    assign bus.out_ResultHigh = res_q[2*W-1:W];
    assign bus.out_Neg        = neg_q;
    assign bus.out_Zero       = zero_q;

endmodule

// File: doc/mul_acc_iter.md
# mul_acc_iter

Parametrised iterative multiply-accumulate unit for the execute stage; successor to the single-cycle multiply path in the ALU. Covers MUL, MLA, MULL and MLAL (signed or unsigned) in one self-contained operation with an internal 2W-bit accumulator, replacing the two-step MLALMul/MLALAdd sequencing. Retires BITS_PER_CYCLE multiplier bits per cycle behind a valid/ready handshake, so the core stalls on it rather than carrying a full-width combinational multiplier.

## Interface
- WIDTH, 32: operand width W.
- BITS_PER_CYCLE, 8: multiplier bits retired per cycle K; must divide WIDTH; iteration count C = WIDTH/BITS_PER_CYCLE.
- clock  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- in_Valid  in  1  request valid
- out_InReady  out  1  unit can accept a request
- in_Op  in  2  00 MUL, 01 MLA, 10 MULL, 11 MLAL
- in_Signed  in  1  operands two's-complement (meaningful for MULL/MLAL; MUL/MLA low word identical either way)
- in_a, in_b  in  W  multiplicand, multiplier
- in_AccLow, in_AccHigh  in  W  accumulate value (AccHigh used by MLAL only)
- in_Flush  in  1  synchronous abort, discards any operation in flight
- out_Valid  out  1  result valid
- in_OutReady  in  1  consumer takes result
- out_ResultLow, out_ResultHigh  out  W  result; High forced 0 for MUL/MLA
- out_Neg, out_Zero  out  1  flags; carry/overflow not produced (caller preserves them)

## Operation
- States: IDLE, MULT, ACC, DONE.
- IDLE: out_InReady=1. in_Valid=1 latches operands and op, clears partial-product register P (2W bits), counter=0, goes to MULT.
- MULT: each cycle P += ext(a) * b[K*i+K-1 : K*i], shifted left K*i; all arithmetic modulo 2^(2W); ext = sign-extend if in_Signed else zero-extend. After C cycles goes to ACC.
- ACC: if signed and b[W-1]=1, subtract ext(a)<<W (two's-complement correction). Add {AccHigh,AccLow} for MLAL, {0,AccLow} for MLA, nothing for MUL/MULL. Registers result and flags, goes to DONE.
- DONE: out_Valid=1; outputs held stable until in_OutReady=1, then to IDLE. out_InReady = in_OutReady in DONE, so a new request is accepted the same cycle the result is taken (next state MULT).
- Flags: long ops: Neg = bit 2W-1, Zero = all 2W bits zero. Short ops: Neg = bit W-1, Zero = low W bits zero.
- in_Flush: any state goes to IDLE next edge, out_Valid drops, result discarded. Flush beats in_Valid in the same cycle: the request is not accepted.
- in_Valid while out_InReady=0: ignored, nothing latched.

## Timing
- Reset: state IDLE, out_InReady=1, out_Valid=0, ResultLow/High=0, Neg=0, Zero=0, P=0.
- Request accepted at edge N: MULT occupies cycles N+1..N+C, ACC cycle N+C+1, out_Valid high after edge N+C+1 (latency C+1; 5 for defaults).
- Throughput: one op per C+2 cycles with in_OutReady held high.
- Reset asserted mid-operation: all outputs to reset values immediately; no partial result ever appears.

## Structure
- Shared package: op encodings (OP_MUL, OP_MLA, OP_MULL, OP_MLAL), state encoding, default WIDTH/BITS_PER_CYCLE.
- One sub-module, mul_iter_step: combinational W x K partial-product generator with sign/zero extension to 2W bits, instantiated once.
- FSM, counter, P register, accumulate/correction adder and flag logic live in mul_acc_iter.

## Test plan
- Unsigned MUL a=0x0000FFFF b=0x00010001 -> ResultLow=0xFFFFFFFF, High=0, Neg=1, Zero=0; out_Valid exactly 5 cycles after accept.
- Signed MULL a=0xFFFFFFFF b=0x00000002 -> {High,Low}=0xFFFFFFFF_FFFFFFFE, Neg=1; same operands unsigned -> 0x00000001_FFFFFFFE, Neg=0.
- Unsigned MLAL a=b=0xFFFFFFFF, Acc=0x00000000_00000001 -> 0xFFFFFFFE_00000002.
- MLA a=0x80000000 b=2 AccLow=0 -> Low=0, High=0, Zero=1, Neg=0.
- Back-pressure: hold in_OutReady=0 for 3 cycles -> outputs stable, out_InReady=0, in_Valid pulses ignored; raise in_OutReady with in_Valid=1 -> new op accepted same cycle.
- in_Flush in 2nd MULT cycle -> out_Valid never rises, out_InReady=1 next cycle; reset pulse mid-MULT -> all outputs 0 immediately, then a fresh MUL 3x5 -> Low=0x0000000F.
